ifid_skid_stage: RTL
====================

Name: ifid_skid_stage

Overview:
- Parametrised next-generation IF/ID boundary register.
- Replaces the plain stall/flush register with a valid/ready handshake and a 2-entry skid buffer, so a stall registers cleanly without a combinational path from decode back to fetch.
- Carries PC, instruction and a sideband field (branch-predict bits) from fetch to decode.
- Supports synchronous flush with bubble insertion, plus saturating stall and flush counters.

Parameters:
- XLEN, 32, width of PC and instruction fields.
- SIDE_W, 1, sideband width (branch prediction bit(s) from fetch).
- BUBBLE_INST, 32'h00000013, instruction presented whenever the stage holds no valid entry (RISC-V NOP).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  stage can accept an entry; registered.
- in_pc  in  XLEN  fetch PC.
- in_inst  in  XLEN  fetched instruction.
- in_side  in  SIDE_W  sideband from fetch.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decode consumes the entry (replaces stall; 0 = stall).
- out_pc  out  XLEN  PC to decode.
- out_inst  out  XLEN  instruction to decode.
- out_side  out  SIDE_W  sideband to decode.
- flush  in  1  synchronous kill of all held entries (mispredict/jump).
- occupancy  out  2  number of valid entries held, 0..2.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- flush_cnt  out  CNT_W  saturating count of effective flushes.

Behaviour:
- Handshake definitions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Payload moves only on push/pop at the rising clk edge.
- Storage: main register (drives the outputs) and skid register.
- States: EMPTY (occupancy 0), ONE (main valid), FULL (main and skid valid).
- Transitions (no flush):
  - EMPTY: push -> ONE, main<=in.
  - EMPTY: no push -> EMPTY.
  - ONE: push & pop -> ONE, main<=in.
  - ONE: push & !pop -> FULL, skid<=in.
  - ONE: !push & pop -> EMPTY.
  - ONE: neither -> ONE, hold.
  - FULL: pop -> ONE, main<=skid.
  - FULL: !pop -> FULL, hold.
  - No push is possible in FULL.
- in_ready is 1 in EMPTY and ONE, 0 in FULL. It is a flop output, updated with the state.
- Latency and throughput:
  - An entry pushed at edge N is visible on the out_* ports after edge N.
  - With out_ready held at 1, throughput is one entry per cycle and in_ready stays 1.
- Ordering: strict FIFO. No entry is lost or duplicated under any pattern of in_valid/out_ready.
- Bubble outputs: whenever out_valid=0, out_pc=0, out_inst=BUBBLE_INST and out_side=0. These are driven from registers, not from muxing raw inputs.
- Flush:
  - Has highest priority; evaluated at the edge.
  - Next state is EMPTY and both entries are invalidated.
  - A simultaneous push is discarded: the input is not captured, even though in_ready may have been 1.
  - A simultaneous pop completes from decode's point of view; the counters treat it as the normal pop.
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 and out_ready=0, including the cycle flush is asserted.
  - Saturates at all-ones.
- flush_cnt:
  - Increments by 1 on each edge where flush=1 and occupancy was nonzero.
  - Flush in EMPTY does not count.
  - Saturates at all-ones.
- Reset (asynchronous, any time, including mid-transfer or in FULL) forces:
  - state EMPTY, occupancy 0, out_valid 0, in_ready 1.
  - out_pc 0, out_inst BUBBLE_INST, out_side 0.
  - Both counters 0.
  - The skid contents are don't-care but invalid.
  - First push is accepted on the first edge after rst deasserts.
- X-safety: out_* must not propagate X from in_* when in_valid=0.

Test Plan:
- Streaming: out_ready=1; push pc 0x0/0x4/0x8 (inst 0x00100093 etc.) on consecutive cycles -> each appears one cycle later, in_ready constant 1, occupancy never above 1, stall_cnt=0.
- Backpressure: out_ready=0; push pc 0x10, 0x14; hold 0x18 on inputs -> occupancy=2 and in_ready=0 after the second push, 0x18 not taken. Release out_ready=1 -> outputs 0x10, 0x14, 0x18 in order with no duplicates, stall_cnt equals the stalled cycle count.
- Flush in FULL with in_valid=1 (pc 0x20) -> next cycle out_valid=0, out_inst=0x00000013, out_pc=0, occupancy=0, flush_cnt=1; 0x20 never appears.
- Flush while EMPTY -> flush_cnt unchanged; flush in ONE together with a pop -> state EMPTY, flush_cnt increments.
- CNT_W=4, 20 consecutive stall cycles -> stall_cnt=15 and holds.
- Assert rst asynchronously (mid-cycle) while FULL -> outputs at reset values immediately, before the next edge; after release, push pc 0x40 -> out_pc=0x40 one cycle later.

Source files
------------

// File: rtl/ifid_skid_stage.sv
// IF/ID boundary: valid/ready handshake with a 2-entry skid buffer, flush and perf counters.
// Latency 1 cycle; in_ready is registered, deasserted only when both entries are held.
module ifid_skid_stage #(
    parameter int                XLEN        = 32,
    parameter int                SIDE_W      = 1,
    parameter logic [XLEN-1:0]   BUBBLE_INST = XLEN'(32'h00000013),
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_inst,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_inst,
    output logic [SIDE_W-1:0] out_side,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [1:0]         r_occ;
    logic [XLEN-1:0]    r_main_pc;
    logic [XLEN-1:0]    r_main_inst;
    logic [SIDE_W-1:0]  r_main_side;
    logic [XLEN-1:0]    r_skid_pc;
    logic [XLEN-1:0]    r_skid_inst;
    logic [SIDE_W-1:0]  r_skid_side;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic w_push;
    logic w_pop;

    always_comb begin
        w_push = in_valid & r_in_ready;
        w_pop  = r_out_valid & out_ready;
    end

    // Main register doubles as the bubble source so outputs never mux raw inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
            r_main_pc   <= '0;
            r_main_inst <= BUBBLE_INST;
            r_main_side <= '0;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
            r_skid_side <= '0;
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
            r_main_pc   <= '0;
            r_main_inst <= BUBBLE_INST;
            r_main_side <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_state     <= S_ONE;
                        r_out_valid <= 1'b1;
                        r_occ       <= 2'd1;
                        r_main_pc   <= in_pc;
                        r_main_inst <= in_inst;
                        r_main_side <= in_side;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        r_main_pc   <= in_pc;
                        r_main_inst <= in_inst;
                        r_main_side <= in_side;
                    end else if (w_push) begin
                        r_state     <= S_FULL;
                        r_in_ready  <= 1'b0;
                        r_occ       <= 2'd2;
                        r_skid_pc   <= in_pc;
                        r_skid_inst <= in_inst;
                        r_skid_side <= in_side;
                    end else if (w_pop) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                        r_occ       <= 2'd0;
                        r_main_pc   <= '0;
                        r_main_inst <= BUBBLE_INST;
                        r_main_side <= '0;
                    end
                end
                S_FULL: begin
                    if (w_pop) begin
                        r_state     <= S_ONE;
                        r_in_ready  <= 1'b1;
                        r_occ       <= 2'd1;
                        r_main_pc   <= r_skid_pc;
                        r_main_inst <= r_skid_inst;
                        r_main_side <= r_skid_side;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_occ       <= 2'd0;
                    r_main_pc   <= '0;
                    r_main_inst <= BUBBLE_INST;
                    r_main_side <= '0;
                end
            endcase
        end
    end

    // A stall is counted even on the flush cycle; flushing an empty stage is not a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_out_valid && !out_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush && (r_state != S_EMPTY) && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_pc    = r_main_pc;
    assign out_inst  = r_main_inst;
    assign out_side  = r_main_side;
    assign occupancy = r_occ;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
